lsu_mem_port: RTL and testbench

// Execute-stage load/store unit: consumes the 6-bit inst_type class codes emitted by the decoder
// (load/store B/H/W/BU/HU) and drives one word-wide memory bus transaction per instruction.

---
 rtl/lsu_mem_port.sv | 186 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit front end: turns one decoded load/store into a single word-wide
// bus transaction, with lane steering, load extension, error detection and a hang timeout.
module lsu_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_type,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        cls_load, cls_store, illegal, misaligned, timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] store_lanes;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign cls_load   = (in_type[5:3] == 3'b011);
    assign cls_store  = (in_type[5:3] == 3'b010);
    assign illegal    = !(cls_load || cls_store) || (in_type[1:0] == 2'b11)
                        || (cls_store && in_type[2]) || ((in_type[1:0] == 2'b10) && in_type[2]);
    assign misaligned = ((in_type[1:0] == 2'b01) && in_addr[0])
                        || ((in_type[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));

    assign lane_be = (in_type[1:0] == 2'b00) ? (4'b0001 << in_addr[1:0]) :
                     (in_type[1:0] == 2'b01) ? (4'b0011 << in_addr[1:0]) : 4'b1111;

    // Each byte lane picks its source byte so narrow stores appear on every lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign store_lanes[8*gi +: 8] =
                (in_type[1:0] == 2'b00) ? in_wdata[7:0] :
                (in_type[1:0] == 2'b01) ? in_wdata[8*(gi%2) +: 8] :
                                          in_wdata[8*gi +: 8];
        end
    endgenerate

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) >= TIMEOUT);

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cnt_d   = 32'd0;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    size_d  = in_type[1:0];
                    uns_d   = in_type[2];
                    off_d   = in_addr[1:0];
                    if (illegal || misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        mem_we_d    = cls_store;
                        mem_be_d    = lane_be;
                        mem_addr_d  = {in_addr[31:2], 2'b00};
                        mem_wdata_d = cls_store ? store_lanes : 32'd0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 32'd1;
                // A grant in the final cycle still wins over the timeout.
                if (mem_gnt) begin
                    if (mem_we_q) begin
                        state_d = ST_DONE;
                    end else if (mem_rvalid) begin
                        rdata_d = load_ext;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid) begin
                    rdata_d = load_ext;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            cnt_q       <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = (state_q == ST_DONE);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a transaction-level model supplies per-cycle
// expectations which a single negedge process compares against the DUT.
module tb_lsu_mem_port;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_type = 6'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'hDEADBEEF;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;

    lsu_mem_port #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_rdata(out_rdata), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    logic        exp_ready, exp_req, exp_ov, exp_we, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [31:0] last_be, last_wdata, last_addr, last_rdata, last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Spec-level model helpers.
    function automatic logic [3:0] m_be(logic [1:0] sz, logic [1:0] off);
        int n = 1 << sz;
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] d);
        if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h01010101;
        if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(logic [5:0] t, logic [31:0] a, logic [31:0] rd);
        logic [31:0] x, mask, v;
        int n;
        n = 1 << t[1:0];
        x = rd >> (8 * a[1:0]);
        if (n == 4) return x;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = x & mask;
        if (!t[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit m_bad(logic [5:0] t, logic [31:0] a);
        bit ld = (t[5:3] == 3'b011);
        bit st = (t[5:3] == 3'b010);
        int sz = int'(t[1:0]);
        if (!ld && !st) return 1'b1;
        if (sz == 3) return 1'b1;
        if (t[2] && (st || sz == 2)) return 1'b1;
        if ((a % (32'd1 << sz)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_req && mem_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_ov && out_valid) begin
                chk("out_rdata", out_rdata, exp_rdata);
                chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
            end
        end
        if (mem_req) begin
            last_be    = {28'd0, mem_be};
            last_wdata = mem_wdata;
            last_addr  = mem_addr;
        end
        if (out_valid) begin
            last_rdata = out_rdata;
            last_err   = {31'd0, out_err};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle();
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_ov    = 1'b0;
    endtask

    task automatic set_bus_exp(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d);
        exp_we    = (t[5:3] == 3'b010);
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = m_be(t[1:0], a[1:0]);
        exp_wdata = m_wdata(t[1:0], d);
    endtask

    // One instruction from accept to completion; gnt_dly >= TO exercises the timeout.
    task automatic run_txn(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rd);
        bit ld;
        int waited;
        ld = (t[5:3] == 3'b011);
        exp_idle();
        in_valid = 1'b1; in_type = t; in_addr = a; in_wdata = d;
        step();
        in_valid = 1'b0; in_type = 6'h3F; in_addr = 32'hFFFFFFFF; in_wdata = 32'h5A5A5A5A;
        exp_ready = 1'b0;
        if (m_bad(t, a)) begin
            exp_ov = 1'b1; exp_err = 1'b1; exp_rdata = 32'd0;
            step();
            exp_idle();
            return;
        end
        exp_req = 1'b1;
        set_bus_exp(t, a, d);
        waited = 0;
        while (waited < gnt_dly && waited < TO) begin
            step();
            waited++;
        end
        if (waited >= TO) begin
            exp_req = 1'b0; exp_ov = 1'b1; exp_err = 1'b1; exp_rdata = 32'd0;
            step();
            exp_idle();
            return;
        end
        mem_gnt = 1'b1;
        if (ld && rv_dly == 0) begin
            mem_rvalid = 1'b1; mem_rdata = rd;
        end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        exp_req = 1'b0;
        if (ld && rv_dly > 0) begin
            for (int i = 0; i < rv_dly - 1; i++) step();
            mem_rvalid = 1'b1; mem_rdata = rd;
            step();
            mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        end
        exp_ov = 1'b1; exp_err = 1'b0;
        exp_rdata = ld ? m_load(t, a, rd) : 32'd0;
        step();
        exp_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_idle();
        exp_we = 1'b0; exp_err = 1'b0; exp_be = 4'd0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_rdata = 32'd0;
        step();
        step();
        check_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        step();

        // Store byte with immediate grant.
        run_txn(6'b010000, 32'h00001003, 32'hAABBCCDD, 0, 0, 32'd0);
        chk("lit_sb_be", last_be, 32'h8);
        chk("lit_sb_wdata", last_wdata, 32'hDDDDDDDD);
        chk("lit_sb_addr", last_addr, 32'h00001000);
        chk("lit_sb_err", last_err, 32'd0);

        // Loads with sign/zero extension.
        run_txn(6'b011000, 32'h00002001, 32'd0, 0, 1, 32'h12348056);
        chk("lit_lb", last_rdata, 32'hFFFFFF80);
        run_txn(6'b011100, 32'h00002001, 32'd0, 0, 1, 32'h12348056);
        chk("lit_lbu", last_rdata, 32'h00000080);
        run_txn(6'b011101, 32'h00002002, 32'd0, 1, 2, 32'h12348056);
        chk("lit_lhu", last_rdata, 32'h00001234);
        run_txn(6'b011001, 32'h00002002, 32'd0, 0, 1, 32'h80001234);
        run_txn(6'b011000, 32'h00002003, 32'd0, 2, 3, 32'h7F000000);
        run_txn(6'b011010, 32'h00003000, 32'd0, 0, 0, 32'hCAFEF00D);
        chk("lit_lw_same", last_rdata, 32'hCAFEF00D);

        // Errors without bus access.
        run_txn(6'b011010, 32'h00003002, 32'd0, 0, 0, 32'd0);
        chk("lit_lw_mis_err", last_err, 32'd1);
        run_txn(6'b010100, 32'h00000010, 32'h1, 0, 0, 32'd0);
        run_txn(6'b011011, 32'h00000020, 32'd0, 0, 0, 32'd0);
        run_txn(6'b000010, 32'h00000020, 32'd0, 0, 0, 32'd0);
        run_txn(6'b011110, 32'h00000020, 32'd0, 0, 0, 32'd0);
        run_txn(6'b010001, 32'h00005001, 32'h1234, 0, 0, 32'd0);

        // Stores with grant withheld.
        run_txn(6'b010001, 32'h00002002, 32'h1234ABCD, 5, 0, 32'd0);
        chk("lit_sh_be", last_be, 32'hC);
        chk("lit_sh_wdata", last_wdata, 32'hABCDABCD);
        run_txn(6'b010010, 32'h00004000, 32'h01234567, 2, 0, 32'd0);

        // Timeout with no grant, then late responses are ignored.
        run_txn(6'b010010, 32'h00006000, 32'h89ABCDEF, 100, 0, 32'd0);
        chk("lit_to_err", last_err, 32'd1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        step();

        // Reset while waiting for load data.
        exp_idle();
        in_valid = 1'b1; in_type = 6'b011010; in_addr = 32'h40;
        step();
        in_valid = 1'b0;
        exp_ready = 1'b0; exp_req = 1'b1;
        set_bus_exp(6'b011010, 32'h40, 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        exp_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
        step();
        run_txn(6'b011010, 32'h00000044, 32'd0, 0, 1, 32'h55AA33CC);
        chk("lit_after_rst", last_rdata, 32'h55AA33CC);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
